// File: rtl/tile_spawner.sv
// tile_spawner: paces LFSR-driven tile spawn events (lane + sequence number) into a small FIFO
// drained over valid/ready. Build macro TILE_SPAWN_NO_REPEAT_EN enables lane repeat avoidance.
module tile_spawner #(
    parameter int LANES    = 4,
    parameter int DEPTH    = 4,
    parameter int PERIOD_W = 8,
    parameter int SEQ_W    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     tick,
    input  logic [PERIOD_W-1:0]      period,
    input  logic [2:0]               random,
    output logic                     tile_valid,
    input  logic                     tile_ready,
    output logic [$clog2(LANES)-1:0] tile_lane,
    output logic [SEQ_W-1:0]         tile_seq,
    output logic                     running,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int LW = $clog2(LANES);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = LW + SEQ_W;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [PERIOD_W-1:0] timer;
    logic [PERIOD_W-1:0] reload;
    logic [LW-1:0]       last_lane;
    logic [LW-1:0]       base_lane;
    logic [LW-1:0]       spawn_lane;
    logic [SEQ_W-1:0]    seq;
    logic [EW-1:0]       mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW:0]         count;
    logic                full;
    logic                pop;
    logic                push;
    logic                spawn;
    logic                unused_bits;

    // A zero period behaves like one, so the reload value is max(period,1)-1.
    assign reload = (period == '0) ? '0 : period - 1'b1;

    // Stop wins over a timer-zero tick, so the spawn is suppressed.
    assign spawn = (state == RUN) && !stop && tick && (timer == '0);

    assign base_lane = random[LW-1:0];
`ifdef TILE_SPAWN_NO_REPEAT_EN
    assign spawn_lane = (base_lane == last_lane) ? base_lane + 1'b1 : base_lane;
`else
    assign spawn_lane = base_lane;
`endif
    assign unused_bits = &{1'b0, random, last_lane};

    assign tile_valid = (count != '0);
    assign full       = (count == FULL_COUNT);
    assign pop        = tile_valid && tile_ready;
    assign push       = spawn && (!full || pop);
    assign {tile_lane, tile_seq} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
            timer   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                        timer   <= reload;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end else if (tick) begin
                        timer <= (timer == '0) ? reload : timer - 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_lane  <= '0;
            seq        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (spawn) begin
                last_lane <= spawn_lane;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                seq    <= seq + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (spawn && !push) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {spawn_lane, seq};
        end
    end

endmodule

// File: doc/tile_spawner.md
# tile_spawner

Consumes the 3-bit pseudo-random value from the LFSR stage and turns it into a paced stream of tile spawn events (lane + sequence number) for the playfield/render stage. A programmable tick-driven timer decides when to spawn. The random value selects the lane. Events are buffered in a small FIFO and drained by the downstream stage over a valid/ready handshake.

## Interface
- `LANES`, 4, number of playfield lanes; fixed at 4, lane is 2 bits.
- `DEPTH`, 4, spawn FIFO depth in entries; power of two, 2..16.
- `PERIOD_W`, 8, width of the spawn-period register.
- `SEQ_W`, 8, width of the tile sequence number.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; enter RUN.
- `stop`  in  1  one-cycle pulse; return to IDLE.
- `tick`  in  1  game-time strobe, one cycle wide; advances the spawn timer.
- `period`  in  PERIOD_W  ticks between spawns; 0 is treated as 1; sampled when the timer reloads.
- `random`  in  3  LFSR output, range 1..7.
- `tile_valid`  out  1  FIFO head is valid.
- `tile_ready`  in  1  downstream accepts the head.
- `tile_lane`  out  2  lane of the head entry.
- `tile_seq`  out  SEQ_W  sequence number of the head entry.
- `running`  out  1  FSM is in RUN.
- `overflow`  out  1  sticky: a spawn was dropped because the FIFO was full; cleared only by `reset`.
- `drop_count`  out  8  saturating count of dropped spawns.

## Operation
- FSM states:
  - IDLE: reset state. `start` → RUN.
  - RUN: `stop` → IDLE. `stop` has priority over `start` in the same cycle.
- Entering RUN loads the timer with `max(period,1)-1`.
- Timer only moves in RUN when `tick`=1:
  - If timer≠0, decrement it.
  - If timer=0, raise a spawn request and reload the timer with `max(period,1)-1`.
- In IDLE the timer holds. FIFO contents are retained and keep draining.
- Lane on a spawn: base lane = `random[1:0]`.
- Repeat avoidance is applied per the Configuration section.
- After lane selection, `last_lane` updates to the final lane. `last_lane` resets to 0.
- Sequence counter:
  - Starts at 0.
  - Increments by 1 modulo 2^SEQ_W on every accepted push.
  - Does not increment on dropped spawns.
  - Wraps 255→0 when SEQ_W=8.
- FIFO entry is {lane, seq}.
- Pop: occurs when `tile_valid` and `tile_ready` are both 1.
- Push: a spawn is pushed if the FIFO is not full, or if it is full and a pop happens in the same cycle.
- Dropped spawn: otherwise the spawn is dropped, `overflow` is set, and `drop_count` increments, saturating at 255.
- Empty FIFO with push: no fall-through. The entry appears at the head the next cycle.
- Push and pop in the same cycle: the occupancy count is unchanged.
- `tile_lane` and `tile_seq` are don't-care when `tile_valid`=0. The bench checks them only while valid.

## Timing
- Reset values (one cycle of `reset` high):
  - FSM IDLE, timer 0, FIFO empty, seq 0, `last_lane` 0.
  - `tile_valid` 0, `running` 0, `overflow` 0, `drop_count` 0.
- `running` is registered and goes high the cycle after `start`.
- Spawn latency: the spawn occurs on the `tick` cycle where timer=0. `tile_valid` rises at the next clock edge when the FIFO was empty.
- With `period`=P and `tick` asserted every cycle from RUN entry:
  - First spawn happens P ticks after RUN entry.
  - Subsequent spawns come every P ticks.
- A `tick` in the same cycle as `start` is ignored.
- A `stop` in the same cycle as a timer-zero `tick` suppresses that spawn.
- `reset` mid-operation: everything returns to reset values at the next edge. In-flight FIFO entries are discarded.
- `random` and `period` are sampled combinationally only in the spawn or reload cycle. They need not be stable otherwise.

## Configuration
- `TILE_SPAWN_NO_REPEAT_EN` defined: if the base lane equals `last_lane`, the final lane is `(base+1) mod 4`. No two consecutive spawned tiles then share a lane.
- Not defined: final lane = base lane. Consecutive repeats are allowed.
- `last_lane` is still tracked in both builds; it is unused logic when the macro is off.

## Test plan
- Basic pacing:
  - Stimulus: reset, `period`=3, `tick` every cycle, `start`, `tile_ready`=1, `random`=3'b110.
  - Expected: first `tile_valid` with lane 2, seq 0 arrives 3 ticks after RUN entry, then 1 entry every 3 cycles with seq 1, 2, 3.
- Repeat avoidance:
  - Stimulus: macro on, `random` held at 3'b101.
  - Expected: lanes alternate 1, 2, 1, 2.
  - With the macro off, all lanes are 1.
- Overflow:
  - Stimulus: DEPTH=4, `tile_ready`=0, `period`=1, 6 spawns.
  - Expected: 4 entries with seq 0..3, `overflow`=1, `drop_count`=2.
  - Then raise `tile_ready`: entries drain in order 0..3 and the next spawn gets seq 4.
- Full with simultaneous pop and push:
  - Stimulus: FIFO full, `tile_ready`=1 on the spawn cycle.
  - Expected: push accepted, no drop, occupancy stays 4.
- Zero period and stop priority:
  - `period`=0 behaves as 1, giving a spawn every tick.
  - `start` and `stop` in the same cycle leave the block in IDLE.
  - `stop` on a timer-zero tick produces no spawn.
- Reset mid-run:
  - Stimulus: 2 entries queued, `reset` high for one cycle.
  - Expected: `tile_valid`=0, `running`=0, seq restarts at 0 after the next `start`.
